// File: rtl/video_scale_nn_down.sv
// video_scale_nn_down
// Nearest-neighbour video downscaler with run-time output resolution and bypass.
// The configuration is latched on each vs_in rising edge. Then a restoring
// divider computes the x and y scale factors, one quotient bit per cycle.
// Each input pixel is kept or dropped by comparing fixed-point accumulators
// against the input coordinate.
//
// Ports
//   pixclk_in                 pixel clock, all logic on its rising edge
//   rst_n                     asynchronous active-low reset
//   cfg_out_xres/yres         requested output resolution (latched at vsync)
//   cfg_bypass                1 = pass video through unscaled
//   vs_in/hs_in/de_in/pix_in  input video
//   vs_out/hs_out/de_out      syncs and data enable, 1 cycle after input
//   pix_out                   kept pixel, 0 when de_out=0
//   out_x/out_y               coordinate of the pixel currently presented
//   sof_out                   pulse with the first kept pixel of a frame
//   cfg_busy                  divider running
//   cfg_err                   sticky config/overrun error, cleared by next valid frame
//   dbg_state                 FSM state (0 IDLE, 1 DIV_X, 2 DIV_Y, 3 RUN)
//
// Stream semantics: de_in/de_out are valid-only qualifiers with no ready.
// A pixel transfers on every clock where de is high. The block never stalls
// its source; pixels that arrive while the divider is busy poison the frame.
module video_scale_nn_down #(
  parameter int IN_XRES = 1920,
  parameter int IN_YRES = 1080,
  parameter int DATA_W  = 24,
  parameter int FRAC_W  = 16,
  parameter int CNT_W   = 12
) (
  input  logic              pixclk_in,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_out_xres,
  input  logic [CNT_W-1:0]  cfg_out_yres,
  input  logic              cfg_bypass,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] pix_in,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [DATA_W-1:0] pix_out,
  output logic [CNT_W-1:0]  out_x,
  output logic [CNT_W-1:0]  out_y,
  output logic              sof_out,
  output logic              cfg_busy,
  output logic              cfg_err,
  output logic [1:0]        dbg_state
);

  localparam int QW    = CNT_W + FRAC_W;  // dividend/quotient width
  localparam int ACC_W = QW + 1;          // integer part may reach ~2x input size
  localparam int DC_W  = $clog2(QW);

  localparam logic [CNT_W-1:0] IN_X_C     = CNT_W'(IN_XRES);
  localparam logic [CNT_W-1:0] IN_Y_C     = CNT_W'(IN_YRES);
  localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(IN_XRES - 1);
  localparam logic [QW-1:0]    DIVIDEND_X = QW'(IN_XRES) << FRAC_W;
  localparam logic [QW-1:0]    DIVIDEND_Y = QW'(IN_YRES) << FRAC_W;
  localparam logic [DC_W-1:0]  DIV_LAST   = DC_W'(QW - 1);
  localparam logic [ACC_W-1:0] SCALE_ONE  = ACC_W'(1) << FRAC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   yres_s;
  logic [CNT_W-1:0]   x_last;
  logic               bypass_s;
  logic               drop;
  logic               sof_pend;
  logic [CNT_W-1:0]   vin_x;
  logic [CNT_W-1:0]   vin_y;
  logic [ACC_W-1:0]   scale_x;
  logic [ACC_W-1:0]   scale_y;
  logic [ACC_W-1:0]   acc_x;
  logic [ACC_W-1:0]   acc_y;
  logic [QW-1:0]      div_q;
  logic [CNT_W:0]     div_r;
  logic [CNT_W-1:0]   div_d;
  logic [DC_W-1:0]    div_cnt;

  logic               vs_rise;
  logic               cfg_bad;
  logic               new_byp;
  logic [CNT_W:0]     acc_x_int;
  logic [CNT_W:0]     acc_y_int;
  logic               keep;
  logic               de_next;
  logic [CNT_W:0]     rem_sh;
  logic               div_ge;
  logic [CNT_W:0]     rem_nx;
  logic [QW-1:0]      q_nx;

  assign dbg_state = state;

  always_comb begin
    // vs_out is vs_in delayed by one cycle, so it doubles as the edge detector.
    vs_rise   = vs_in & ~vs_out;
    // A bypass frame never uses the resolution, so it cannot be invalid.
    cfg_bad   = ~cfg_bypass &&
                ((cfg_out_xres == '0) || (cfg_out_yres == '0) ||
                 (cfg_out_xres > IN_X_C) || (cfg_out_yres > IN_Y_C));
    new_byp   = cfg_bypass | cfg_bad;
    acc_x_int = acc_x[ACC_W-1:FRAC_W];
    acc_y_int = acc_y[ACC_W-1:FRAC_W];
    // vin_y saturates at IN_YRES, which marks surplus lines.
    keep      = (vin_y != IN_Y_C) &&
                (acc_x_int == {1'b0, vin_x}) && (acc_y_int == {1'b0, vin_y});
    de_next   = (state == RUN) && de_in && !vs_rise && !drop && (bypass_s || keep);
    // One restoring-division step.
    rem_sh    = {div_r[CNT_W-1:0], div_q[QW-1]};
    div_ge    = rem_sh >= {1'b0, div_d};
    rem_nx    = div_ge ? (rem_sh - {1'b0, div_d}) : rem_sh;
    q_nx      = {div_q[QW-2:0], div_ge};
  end

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vs_out   <= 1'b0;
      hs_out   <= 1'b0;
      de_out   <= 1'b0;
      pix_out  <= '0;
      out_x    <= '0;
      out_y    <= '0;
      sof_out  <= 1'b0;
      cfg_busy <= 1'b0;
      cfg_err  <= 1'b0;
      yres_s   <= '0;
      x_last   <= '0;
      bypass_s <= 1'b0;
      drop     <= 1'b0;
      sof_pend <= 1'b0;
      vin_x    <= '0;
      vin_y    <= '0;
      scale_x  <= SCALE_ONE;
      scale_y  <= SCALE_ONE;
      acc_x    <= '0;
      acc_y    <= '0;
      div_q    <= '0;
      div_r    <= '0;
      div_d    <= '0;
      div_cnt  <= '0;
    end else begin
      vs_out  <= vs_in;
      hs_out  <= hs_in;
      de_out  <= de_next;
      pix_out <= de_next ? pix_in : '0;
      sof_out <= de_next & sof_pend;
      if (de_next) sof_pend <= 1'b0;

      if (vs_rise) begin
        // A new frame restarts everything; a pixel on this cycle is discarded.
        yres_s   <= cfg_out_yres;
        bypass_s <= new_byp;
        cfg_err  <= cfg_bad;
        x_last   <= new_byp ? X_LAST : (cfg_out_xres - CNT_W'(1));
        drop     <= 1'b0;
        sof_pend <= 1'b1;
        vin_x    <= '0;
        vin_y    <= '0;
        acc_x    <= '0;
        acc_y    <= '0;
        out_x    <= '0;
        out_y    <= '0;
        div_q    <= DIVIDEND_X;
        div_r    <= '0;
        div_d    <= cfg_out_xres;
        div_cnt  <= '0;
        cfg_busy <= ~new_byp;
        state    <= new_byp ? RUN : DIV_X;
      end else begin
        // out_x/out_y name the pixel on the output now and advance after it.
        if (de_out) begin
          if (out_x == x_last) begin
            out_x <= '0;
            out_y <= out_y + CNT_W'(1);
          end else begin
            out_x <= out_x + CNT_W'(1);
          end
        end

        case (state)
          DIV_X, DIV_Y: begin
            if (de_in) begin
              drop    <= 1'b1;
              cfg_err <= 1'b1;
            end
            div_q   <= q_nx;
            div_r   <= rem_nx;
            div_cnt <= div_cnt + DC_W'(1);
            if (div_cnt == DIV_LAST) begin
              if (state == DIV_X) begin
                scale_x <= ACC_W'(q_nx) + ACC_W'(1);
                div_q   <= DIVIDEND_Y;
                div_r   <= '0;
                div_d   <= yres_s;
                div_cnt <= '0;
                state   <= DIV_Y;
              end else begin
                scale_y  <= ACC_W'(q_nx) + ACC_W'(1);
                cfg_busy <= 1'b0;
                state    <= RUN;
              end
            end
          end
          RUN: begin
            if (de_in) begin
              if (vin_x == X_LAST) begin
                vin_x <= '0;
                acc_x <= '0;
                if (vin_y != IN_Y_C) vin_y <= vin_y + CNT_W'(1);
                if (acc_y_int <= {1'b0, vin_y}) acc_y <= acc_y + scale_y;
              end else begin
                vin_x <= vin_x + CNT_W'(1);
                if (acc_x_int <= {1'b0, vin_x}) acc_x <= acc_x + scale_x;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_scale_nn_down.sv
// Testbench for video_scale_nn_down on a reduced 24x12 input raster.
module tb_video_scale_nn_down;

  localparam int IN_XRES = 24;
  localparam int IN_YRES = 12;
  localparam int DATA_W  = 24;
  localparam int FRAC_W  = 16;
  localparam int CNT_W   = 12;
  localparam int EW      = 2 * CNT_W + DATA_W;
  localparam int DIV_GAP = 70;

  // ---------------- clock / reset ----------------
  logic              pixclk_in = 1'b0;
  logic              rst_n     = 1'b0;
  logic [CNT_W-1:0]  cfg_out_xres = '0;
  logic [CNT_W-1:0]  cfg_out_yres = '0;
  logic              cfg_bypass = 1'b0;
  logic              vs_in = 1'b0;
  logic              hs_in = 1'b0;
  logic              de_in = 1'b0;
  logic [DATA_W-1:0] pix_in = '0;
  logic              vs_out, hs_out, de_out, sof_out, cfg_busy, cfg_err;
  logic [DATA_W-1:0] pix_out;
  logic [CNT_W-1:0]  out_x, out_y;
  logic [1:0]        dbg_state;

  always #5 pixclk_in = ~pixclk_in;

  video_scale_nn_down #(
    .IN_XRES(IN_XRES), .IN_YRES(IN_YRES), .DATA_W(DATA_W),
    .FRAC_W(FRAC_W), .CNT_W(CNT_W)
  ) dut (
    .pixclk_in(pixclk_in), .rst_n(rst_n),
    .cfg_out_xres(cfg_out_xres), .cfg_out_yres(cfg_out_yres), .cfg_bypass(cfg_bypass),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .pix_in(pix_in),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .pix_out(pix_out),
    .out_x(out_x), .out_y(out_y), .sof_out(sof_out),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int compare_cnt  = 0;
  int mismatch_cnt = 0;
  logic [EW-1:0] exp_q[$];
  bit m_kx[IN_XRES];
  bit m_ky[IN_YRES];
  int m_ox, m_oy, m_xlast;
  bit m_drop;
  int frame_outs = 0;
  logic vs_d = 1'b0;
  logic hs_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compare_cnt++;
    if (act !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge pixclk_in) begin
    vs_d <= vs_in;
    hs_d <= hs_in;
  end

  always @(negedge pixclk_in) begin
    if (rst_n) begin
      check("vs_out", vs_out, vs_d);
      check("hs_out", hs_out, hs_d);
      if (de_out) begin
        check("sof_out", sof_out, frame_outs == 0);
        if (exp_q.size() == 0) check("de_out_extra", de_out, 0);
        else check("pixel", {out_x, out_y, pix_out}, exp_q.pop_front());
        frame_outs++;
      end else begin
        check("idle_pix", pix_out, 0);
        check("idle_sof", sof_out, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pixclk_in);
    #1;
  endtask

  task automatic setup_model(input int xres, input int yres, input bit byp);
    bit bad, eb;
    longint sx, sy, v;
    bad = !byp && (xres == 0 || yres == 0 || xres > IN_XRES || yres > IN_YRES);
    eb  = byp || bad;
    for (int i = 0; i < IN_XRES; i++) m_kx[i] = eb;
    for (int i = 0; i < IN_YRES; i++) m_ky[i] = eb;
    if (!eb) begin
      // Nearest neighbour: output k samples input floor(k*scale).
      sx = ((longint'(IN_XRES) << FRAC_W) / xres) + 1;
      sy = ((longint'(IN_YRES) << FRAC_W) / yres) + 1;
      for (int k = 0; k <= IN_XRES; k++) begin
        v = (k * sx) >> FRAC_W;
        if (v < IN_XRES) m_kx[int'(v)] = 1'b1;
      end
      for (int k = 0; k <= IN_YRES; k++) begin
        v = (k * sy) >> FRAC_W;
        if (v < IN_YRES) m_ky[int'(v)] = 1'b1;
      end
    end
    m_xlast = eb ? IN_XRES - 1 : xres - 1;
  endtask

  task automatic start_frame(input int xres, input int yres, input bit byp, input bit early);
    bit bad;
    bad = !byp && (xres == 0 || yres == 0 || xres > IN_XRES || yres > IN_YRES);
    setup_model(xres, yres, byp);
    m_drop = early;
    m_ox = 0;
    m_oy = 0;
    frame_outs = 0;
    cfg_out_xres = CNT_W'(xres);
    cfg_out_yres = CNT_W'(yres);
    cfg_bypass = byp;
    // Pixel on the vsync edge must be discarded.
    vs_in = 1'b1;
    de_in = 1'b1;
    pix_in = DATA_W'($urandom);
    tick();
    de_in = 1'b0;
    // Mid-frame config changes must be ignored.
    cfg_out_xres = CNT_W'($urandom_range(0, 40));
    cfg_out_yres = CNT_W'($urandom_range(0, 20));
    cfg_bypass = 1'($urandom_range(0, 1));
    repeat (4) tick();
    check("cfg_busy", cfg_busy, !(byp || bad));
    vs_in = 1'b0;
    for (int c = 0; c < DIV_GAP; c++) begin
      de_in = early && (c == 5);
      tick();
    end
    de_in = 1'b0;
  endtask

  task automatic drive_px(input int x, input int y, input bit model_on);
    hs_in = 1'b0;
    de_in = 1'b1;
    pix_in = DATA_W'($urandom);
    if (model_on && !m_drop && y < IN_YRES && m_kx[x] && m_ky[y]) begin
      exp_q.push_back({CNT_W'(m_ox), CNT_W'(m_oy), pix_in});
      if (m_ox == m_xlast) begin
        m_ox = 0;
        m_oy++;
      end else begin
        m_ox++;
      end
    end
    tick();
  endtask

  task automatic drive_line(input int y);
    for (int x = 0; x < IN_XRES; x++) drive_px(x, y, 1'b1);
    de_in = 1'b0;
    pix_in = '0;
    hs_in = 1'b1;
    repeat (3) tick();
    hs_in = 1'b0;
  endtask

  task automatic finish_frame(input int exp_n, input bit exp_err);
    repeat (3) tick();
    check("frame_count", frame_outs, exp_n);
    check("queue_empty", exp_q.size(), 0);
    check("cfg_err", cfg_err, exp_err);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_de"}, de_out, 0);
    check({tag, "_pix"}, pix_out, 0);
    check({tag, "_xy"}, {out_x, out_y}, 0);
    check({tag, "_sync"}, {vs_out, hs_out, sof_out}, 0);
    check({tag, "_cfg"}, {cfg_busy, cfg_err}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int xres;
    int yres;
    bit byp;
    bit early;
    bit extra;
    int exp_n;
    bit exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{12,   6,  1'b0, 1'b0, 1'b0, 72,  1'b0};  // half size
    vecs[1]  = '{8,    4,  1'b0, 1'b0, 1'b0, 32,  1'b0};  // third size
    vecs[2]  = '{16,   8,  1'b0, 1'b0, 1'b0, 128, 1'b0};  // factor 1.5
    vecs[3]  = '{12,   6,  1'b1, 1'b0, 1'b0, 288, 1'b0};  // bypass
    vecs[4]  = '{0,    6,  1'b0, 1'b0, 1'b0, 288, 1'b1};  // xres 0
    vecs[5]  = '{2000, 6,  1'b0, 1'b0, 1'b0, 288, 1'b1};  // xres too big
    vecs[6]  = '{12,   6,  1'b0, 1'b0, 1'b0, 72,  1'b0};  // clears error
    vecs[7]  = '{12,   6,  1'b0, 1'b1, 1'b0, 0,   1'b1};  // overrun
    vecs[8]  = '{24,   12, 1'b0, 1'b0, 1'b1, 288, 1'b0};  // identity + surplus line
    vecs[9]  = '{1,    1,  1'b0, 1'b0, 1'b0, 1,   1'b0};  // single pixel
    vecs[10] = '{12,   13, 1'b0, 1'b0, 1'b0, 288, 1'b1};  // yres too big
    vecs[11] = '{8,    4,  1'b0, 1'b0, 1'b0, 32,  1'b0};  // recovers

    // reset state
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) begin
      start_frame(vecs[i].xres, vecs[i].yres, vecs[i].byp, vecs[i].early);
      for (int y = 0; y < IN_YRES + (vecs[i].extra ? 1 : 0); y++) drive_line(y);
      finish_frame(vecs[i].exp_n, vecs[i].exp_err);
    end

    // Reset pulsed mid-line while a kept pixel is on the output.
    start_frame(12, 6, 1'b0, 1'b0);
    for (int x = 0; x < 6; x++) drive_px(x, 0, 1'b1);
    de_in = 1'b1;
    pix_in = DATA_W'($urandom);
    @(posedge pixclk_in);
    #2;
    check("pre_reset_de", {de_out, out_x}, {1'b1, CNT_W'(3)});
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    de_in = 1'b0;
    hs_in = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    start_frame(12, 6, 1'b0, 1'b0);
    for (int y = 0; y < IN_YRES; y++) drive_line(y);
    finish_frame(72, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/video_scale_nn_down.md
Name: video_scale_nn_down

Overview:
Parametrised nearest-neighbour video downscaler, successor to the fixed 1920x1080 scaler in the capture-to-DDR write path. Output resolution and a bypass mode are run-time configurable, latched once per frame at vsync. Scale factors are computed by an internal sequential divider, so the design carries no combinational divider. Adds output pixel/line counters, a start-of-frame pulse and config error reporting.

Parameters:
IN_XRES, 1920, active input pixels per line
IN_YRES, 1080, active input lines per frame
DATA_W, 24, pixel width ({r,g,b})
FRAC_W, 16, fractional bits of the scale accumulators
CNT_W, 12, width of the coordinate and config counters

Ports:
pixclk_in  in  1  pixel clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
cfg_out_xres  in  CNT_W  requested output width
cfg_out_yres  in  CNT_W  requested output height
cfg_bypass  in  1  1 = pass the video through unscaled
vs_in / hs_in / de_in  in  1  input syncs (active high) and data enable
pix_in  in  DATA_W  input pixel
vs_out / hs_out / de_out  out  1  output syncs and data enable
pix_out  out  DATA_W  output pixel; 0 when de_out=0
out_x / out_y  out  CNT_W  coordinate of the current output pixel
sof_out  out  1  one-cycle pulse on the first kept pixel of a frame
cfg_busy  out  1  divider running
cfg_err  out  1  sticky error; cleared by the next frame with a valid config

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0. FSM enters IDLE. Shadow scale_x and scale_y = 1<<FRAC_W. All counters and accumulators = 0.
- FSM states: IDLE -> DIV_X -> DIV_Y -> RUN.
  - On a vs_in rising edge in any state: latch cfg_* into shadow registers, clear vin_x, vin_y, acc_x, acc_y, out_x and out_y, then go to DIV_X.
  - Exception: bypass, or an invalid config, goes straight to RUN.
  - Invalid config: out_xres=0, out_yres=0, out_xres>IN_XRES or out_yres>IN_YRES. Effect: cfg_err=1 and the frame runs as bypass.
- Divider: restoring division, 1 quotient bit per cycle, CNT_W+FRAC_W cycles per factor.
  - DIV_X computes scale_x = ((IN_XRES<<FRAC_W)/out_xres)+1.
  - DIV_Y then computes scale_y the same way from IN_YRES and out_yres.
  - cfg_busy=1 throughout DIV_X and DIV_Y.
- Overrun: de_in=1 while in DIV_X or DIV_Y -> the whole frame is dropped (de_out held 0 until the next vs), cfg_err=1, and the divider still completes.
- RUN, per de_in=1 cycle:
  - keep = (acc_x[int]==vin_x) && (acc_y[int]==vin_y).
  - If acc_x[int]<=vin_x: acc_x += scale_x.
  - vin_x increments. When vin_x=IN_XRES-1: vin_x<=0, acc_x<=0, vin_y++, and if acc_y[int]<=vin_y: acc_y += scale_y.
  - Extra input lines beyond IN_YRES are ignored (de_out=0).
- Output register, latency exactly 1 cycle from input to output:
  - vs_out and hs_out always follow vs_in and hs_in, delayed 1 cycle.
  - de_out = de_in && keep (bypass: de_in).
  - pix_out = pix_in when kept, else 0.
- Output counters:
  - out_x holds the index of the pixel currently presented and increments after each de_out.
  - Kept line end (last kept pixel of a kept row): out_x<=0, out_y++.
  - Bypass mode: counters run over IN_XRES x IN_YRES.
  - sof_out = 1 with the first de_out after a vs.
- Simultaneous events:
  - vs_in rising at the same time as de_in: vs wins, and that pixel is discarded.
  - cfg_* changes mid-frame are ignored until the next vs.

Test Plan:
- 960x540, full 1920x1080 frame -> 960 de_out per kept line, 540 kept lines, kept input x=0,2,...,1918, y even; scale_x=0x20001; sof_out pulses once.
- 640x360 -> kept x=0,3,...,1917; out_x reaches 639, out_y reaches 359; pix_out matches pix_in of the kept coordinate, 1 cycle late.
- 1280x720 (factor 1.5) -> kept x=0,1,3,4,6,...; exactly 1280 per line; last kept x=1918.
- cfg_bypass=1 -> de_out is de_in delayed 1 cycle; 1920x1080 outputs; pixels unchanged.
- out_xres=0, then out_xres=2000 -> cfg_err=1 and the frame passes through as bypass; a following valid frame clears cfg_err.
- de_in asserted 10 cycles after vs (divider busy) -> no de_out for that frame, cfg_err=1. rst_n pulsed mid-line -> outputs 0 at once, and scaling resumes correctly at the next vs.
